// File: rtl/clint_ctrl_pkg.sv
// Shared constants for the CLINT control block: CSR addresses, mcause codes,
// mstatus bit positions and FSM state encoding.
package clint_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] MCAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] MCAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] MCAUSE_M_TIMER    = 32'h8000_0007;
    localparam logic [31:0] MCAUSE_M_EXT      = 32'h8000_000B;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    typedef enum logic [2:0] {
        StIdle,
        StWMepc,
        StWMcause,
        StWMstatus,
        StWMret,
        StAssert
    } clint_state_e;

    // CSR addresses travel zero-extended on the 32-bit write port.
    function automatic logic [31:0] csr_port_addr(input logic [11:0] addr);
        return {20'b0, addr};
    endfunction

endpackage

// File: rtl/clint_cause_enc.sv
// Combinational priority encoder from execute-stage events to trap request.
// Optional external interrupt source enabled by CLINT_EXT_IRQ_EN.
module clint_cause_enc
    import clint_ctrl_pkg::*;
(
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        timer_irq_i,
`ifdef CLINT_EXT_IRQ_EN
    input  logic        ext_irq_i,
`endif
    input  logic        mie_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        take_o,
    output logic        is_mret_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mepc_o
);

    logic [31:0] async_mepc;

    // An interrupt squashes the instruction in execute, so it re-executes on return;
    // if execute was redirecting, the redirect target is the instruction to resume at.
    assign async_mepc = jump_flag_i ? jump_addr_i : inst_addr_i;

    always_comb begin
        take_o    = 1'b0;
        is_mret_o = 1'b0;
        mcause_o  = 32'd0;
        mepc_o    = 32'd0;
        if (ecall_i) begin
            take_o   = 1'b1;
            mcause_o = MCAUSE_ECALL_M;
            mepc_o   = inst_addr_i;
        end else if (ebreak_i) begin
            take_o   = 1'b1;
            mcause_o = MCAUSE_BREAKPOINT;
            mepc_o   = inst_addr_i;
        end else if (mret_i) begin
            take_o    = 1'b1;
            is_mret_o = 1'b1;
`ifdef CLINT_EXT_IRQ_EN
        end else if (ext_irq_i && mie_i) begin
            take_o   = 1'b1;
            mcause_o = MCAUSE_M_EXT;
            mepc_o   = async_mepc;
`endif
        end else if (timer_irq_i && mie_i) begin
            take_o   = 1'b1;
            mcause_o = MCAUSE_M_TIMER;
            mepc_o   = async_mepc;
        end
    end

endmodule

// File: rtl/clint_ctrl.sv
// CLINT control: sequences mepc/mcause/mstatus writes on trap entry, mstatus on mret,
// then redirects the PC. External interrupt source enabled by CLINT_EXT_IRQ_EN.
module clint_ctrl
    import clint_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_addr_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        timer_irq_i,
`ifdef CLINT_EXT_IRQ_EN
    input  logic        ext_irq_i,
`endif
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        clint_wr_en_o,
    output logic [31:0] clint_wr_addr_o,
    output logic [31:0] clint_wr_data_o,
    output logic        hold_flag_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    clint_state_e state_q, state_d;
    logic [31:0]  mepc_q, mepc_d;
    logic [31:0]  mcause_q, mcause_d;
    logic         is_mret_q, is_mret_d;

    logic         take;
    logic         is_mret;
    logic [31:0]  enc_mcause;
    logic [31:0]  enc_mepc;

    clint_cause_enc u_cause_enc (
        .ecall_i     (ecall_i),
        .ebreak_i    (ebreak_i),
        .mret_i      (mret_i),
        .timer_irq_i (timer_irq_i),
`ifdef CLINT_EXT_IRQ_EN
        .ext_irq_i   (ext_irq_i),
`endif
        .mie_i       (csr_mstatus_i[MSTATUS_MIE]),
        .inst_addr_i (inst_addr_i),
        .jump_flag_i (jump_flag_i),
        .jump_addr_i (jump_addr_i),
        .take_o      (take),
        .is_mret_o   (is_mret),
        .mcause_o    (enc_mcause),
        .mepc_o      (enc_mepc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mepc_q    <= 32'd0;
            mcause_q  <= 32'd0;
            is_mret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            is_mret_q <= is_mret_d;
        end
    end

    // Next state; events are only sampled in idle since the pipeline is held otherwise.
    always_comb begin
        state_d   = state_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        is_mret_d = is_mret_q;
        case (state_q)
            StIdle: begin
                if (take) begin
                    mepc_d    = enc_mepc;
                    mcause_d  = enc_mcause;
                    is_mret_d = is_mret;
                    state_d   = is_mret ? StWMret : StWMepc;
                end
            end
            StWMepc:    state_d = StWMcause;
            StWMcause:  state_d = StWMstatus;
            StWMstatus: state_d = StAssert;
            StWMret:    state_d = StAssert;
            StAssert:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        clint_wr_en_o   = 1'b0;
        clint_wr_addr_o = 32'd0;
        clint_wr_data_o = 32'd0;
        hold_flag_o     = 1'b1;
        int_assert_o    = 1'b0;
        int_addr_o      = 32'd0;
        case (state_q)
            StIdle: begin
                hold_flag_o = take;
            end
            StWMepc: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = csr_port_addr(CSR_MEPC);
                clint_wr_data_o = mepc_q;
            end
            StWMcause: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = csr_port_addr(CSR_MCAUSE);
                clint_wr_data_o = mcause_q;
            end
            StWMstatus: begin
                // Stash the interrupt enable in MPIE and mask interrupts in the handler.
                clint_wr_en_o                 = 1'b1;
                clint_wr_addr_o               = csr_port_addr(CSR_MSTATUS);
                clint_wr_data_o               = csr_mstatus_i;
                clint_wr_data_o[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
                clint_wr_data_o[MSTATUS_MIE]  = 1'b0;
            end
            StWMret: begin
                clint_wr_en_o                 = 1'b1;
                clint_wr_addr_o               = csr_port_addr(CSR_MSTATUS);
                clint_wr_data_o               = csr_mstatus_i;
                clint_wr_data_o[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
                clint_wr_data_o[MSTATUS_MPIE] = 1'b1;
            end
            StAssert: begin
                int_assert_o = 1'b1;
                int_addr_o   = is_mret_q ? csr_mepc_i : csr_mtvec_i;
            end
            default: begin
                hold_flag_o = 1'b0;
            end
        endcase
    end

endmodule
